// File: rtl/priority_resolver.sv
// Priority resolver for an 8-level interrupt controller: IRR capture (edge or
// level), rotating priority arbitration against the in-service register, the
// two-pulse INTA acknowledge sequence and EOI handling.
module priority_resolver (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ir,
    input  logic       level_mode,
    input  logic [7:0] imr,
    input  logic       auto_eoi,
    input  logic       inta_n,
    input  logic       eoi_valid,
    input  logic       eoi_specific,
    input  logic [2:0] eoi_level,
    input  logic       eoi_rotate,
    output logic       int_request,
    output logic [2:0] interrupt_index,
    output logic [7:0] irr,
    output logic [7:0] isr,
    output logic       vector_valid,
    output logic [2:0] vector_index
);

    typedef enum logic [1:0] {IDLE, ACK1, ACK2} state_t;

    state_t     state_q, state_d;
    logic [7:0] ir_q;
    logic       inta_q;
    logic [7:0] irr_q, irr_d;
    logic [7:0] isr_q, isr_d;
    logic [2:0] lp_q, lp_d;
    logic       int_request_q, int_request_d;
    logic [2:0] index_q, index_d;
    logic       spurious_q, spurious_d;
    logic       vector_valid_q, vector_valid_d;
    logic [2:0] vector_index_q, vector_index_d;

    logic [7:0] isr_set, isr_clr;
    logic [3:0] win_top, isr_top;
    logic       win_valid, nested_ok, inta_fall;
    logic [2:0] win_lvl;

    // Scan from highest priority (lowest+1) downward; returns {found, level}.
    function automatic logic [3:0] find_top(input logic [7:0] vec, input logic [2:0] lowest);
        logic [3:0] res;
        logic [2:0] lvl;
        res = 4'd0;
        for (int k = 7; k >= 0; k--) begin
            lvl = lowest + 3'd1 + 3'(k);
            if (vec[lvl]) res = {1'b1, lvl};
        end
        return res;
    endfunction

    // Distance from the highest-priority slot; 0 is the most urgent.
    function automatic logic [2:0] rank_of(input logic [2:0] lvl, input logic [2:0] lowest);
        return lvl - lowest - 3'd1;
    endfunction

    assign win_top   = find_top(irr_q & ~imr, lp_q);
    assign isr_top   = find_top(isr_q, lp_q);
    assign win_valid = win_top[3];
    assign win_lvl   = win_top[2:0];
    assign nested_ok = !isr_top[3] || (rank_of(win_lvl, lp_q) < rank_of(isr_top[2:0], lp_q));
    assign inta_fall = inta_q & ~inta_n;

    // Next-state logic: acknowledge sequencing, IRR capture, ISR set/clear and rotation.
    always_comb begin
        state_d        = state_q;
        irr_d          = level_mode ? ir : (irr_q | (ir & ~ir_q));
        isr_set        = 8'd0;
        isr_clr        = 8'd0;
        lp_d           = lp_q;
        int_request_d  = 1'b0;
        index_d        = index_q;
        spurious_d     = spurious_q;
        vector_valid_d = 1'b0;
        vector_index_d = vector_index_q;

        case (state_q)
            IDLE: begin
                if (inta_fall) begin
                    state_d    = ACK1;
                    index_d    = win_valid ? win_lvl : 3'd7;
                    spurious_d = !win_valid;
                    if (win_valid) begin
                        isr_set[win_lvl] = 1'b1;
                        irr_d[win_lvl]   = 1'b0;
                    end
                end else begin
                    int_request_d = win_valid && nested_ok;
                    if (win_valid) index_d = win_lvl;
                end
            end
            ACK1: begin
                if (inta_fall) begin
                    state_d        = ACK2;
                    vector_valid_d = 1'b1;
                    vector_index_d = index_q;
                    if (auto_eoi && !spurious_q) isr_clr[index_q] = 1'b1;
                    if (auto_eoi && eoi_rotate) lp_d = index_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // EOI target comes from the registered ISR, so it ignores a same-cycle set.
        if (eoi_valid) begin
            if (eoi_specific) begin
                isr_clr[eoi_level] = 1'b1;
                if (eoi_rotate) lp_d = eoi_level;
            end else if (isr_top[3]) begin
                isr_clr[isr_top[2:0]] = 1'b1;
                if (eoi_rotate) lp_d = isr_top[2:0];
            end
        end

        isr_d = (isr_q | isr_set) & ~isr_clr;
    end

    // Acknowledge FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Request/service registers, priority pointer and input samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_q           <= 8'd0;
            inta_q         <= 1'b1;
            irr_q          <= 8'd0;
            isr_q          <= 8'd0;
            lp_q           <= 3'd7;
            int_request_q  <= 1'b0;
            index_q        <= 3'd0;
            spurious_q     <= 1'b0;
            vector_valid_q <= 1'b0;
            vector_index_q <= 3'd0;
        end else begin
            ir_q           <= ir;
            inta_q         <= inta_n;
            irr_q          <= irr_d;
            isr_q          <= isr_d;
            lp_q           <= lp_d;
            int_request_q  <= int_request_d;
            index_q        <= index_d;
            spurious_q     <= spurious_d;
            vector_valid_q <= vector_valid_d;
            vector_index_q <= vector_index_d;
        end
    end

    assign int_request     = int_request_q;
    assign interrupt_index = index_q;
    assign irr             = irr_q;
    assign isr             = isr_q;
    assign vector_valid    = vector_valid_q;
    assign vector_index    = vector_index_q;

endmodule

// File: tb/tb_priority_resolver.sv
// Bench for priority_resolver: directed vector table, hand-written corner
// sequences, then randomized traffic against a behavioural model.
module tb_priority_resolver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] ir;
    logic       level_mode;
    logic [7:0] imr;
    logic       auto_eoi;
    logic       inta_n;
    logic       eoi_valid;
    logic       eoi_specific;
    logic [2:0] eoi_level;
    logic       eoi_rotate;
    logic       int_request;
    logic [2:0] interrupt_index;
    logic [7:0] irr;
    logic [7:0] isr;
    logic       vector_valid;
    logic [2:0] vector_index;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    priority_resolver dut (
        .clk(clk), .rst_n(rst_n), .ir(ir), .level_mode(level_mode), .imr(imr),
        .auto_eoi(auto_eoi), .inta_n(inta_n), .eoi_valid(eoi_valid),
        .eoi_specific(eoi_specific), .eoi_level(eoi_level), .eoi_rotate(eoi_rotate),
        .int_request(int_request), .interrupt_index(interrupt_index), .irr(irr),
        .isr(isr), .vector_valid(vector_valid), .vector_index(vector_index)
    );

    // ---------------- behavioural reference model ----------------
    // phase: 0 = waiting, 1 = first INTA seen, 2 = second INTA seen
    logic [7:0] m_irr, m_isr, m_ir_prev, n_irr, n_isr;
    logic       m_inta_prev, m_req, n_req, m_vv, n_vv, m_spur, n_spur;
    int         m_lp, n_lp, m_idx, n_idx, m_vi, n_vi, m_phase, n_phase;
    int         win, itop;
    logic       fall;

    function automatic int prio_rank(int lvl, int lp);
        return (lvl - lp + 7) % 8;
    endfunction

    function automatic int top_of(logic [7:0] v, int lp);
        int best = -1;
        for (int i = 0; i < 8; i++)
            if (v[i] && (best < 0 || prio_rank(i, lp) < prio_rank(best, lp))) best = i;
        return best;
    endfunction

    always_comb begin
        win     = top_of(m_irr & ~imr, m_lp);
        itop    = top_of(m_isr, m_lp);
        fall    = m_inta_prev && !inta_n;
        n_irr   = level_mode ? ir : (m_irr | (ir & ~m_ir_prev));
        n_isr   = m_isr;
        n_lp    = m_lp;
        n_req   = 1'b0;
        n_vv    = 1'b0;
        n_vi    = m_vi;
        n_idx   = m_idx;
        n_phase = m_phase;
        n_spur  = m_spur;
        if (m_phase == 0) begin
            if (fall) begin
                n_phase = 1;
                n_spur  = (win < 0);
                n_idx   = (win < 0) ? 7 : win;
                if (win >= 0) begin
                    n_isr[win] = 1'b1;
                    n_irr[win] = 1'b0;
                end
            end else begin
                if (win >= 0) n_idx = win;
                n_req = (win >= 0) && (itop < 0 || prio_rank(win, m_lp) < prio_rank(itop, m_lp));
            end
        end else if (m_phase == 1) begin
            if (fall) begin
                n_phase = 2;
                n_vv    = 1'b1;
                n_vi    = m_idx;
                if (auto_eoi && !m_spur) n_isr[m_idx] = 1'b0;
                if (auto_eoi && eoi_rotate) n_lp = m_idx;
            end
        end else begin
            n_phase = 0;
        end
        if (eoi_valid) begin
            if (eoi_specific) begin
                n_isr[eoi_level] = 1'b0;
                if (eoi_rotate) n_lp = int'(eoi_level);
            end else if (itop >= 0) begin
                n_isr[itop] = 1'b0;
                if (eoi_rotate) n_lp = itop;
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_irr <= 8'd0; m_isr <= 8'd0; m_ir_prev <= 8'd0; m_inta_prev <= 1'b1;
            m_lp <= 7; m_req <= 1'b0; m_idx <= 0; m_vv <= 1'b0; m_vi <= 0;
            m_phase <= 0; m_spur <= 1'b0;
        end else begin
            m_irr <= n_irr; m_isr <= n_isr; m_ir_prev <= ir; m_inta_prev <= inta_n;
            m_lp <= n_lp; m_req <= n_req; m_idx <= n_idx; m_vv <= n_vv; m_vi <= n_vi;
            m_phase <= n_phase; m_spur <= n_spur;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_irr"}, irr, 8'h00);
        check({tag, "_isr"}, isr, 8'h00);
        check({tag, "_req"}, 8'(int_request), 8'h00);
        check({tag, "_idx"}, 8'(interrupt_index), 8'h00);
        check({tag, "_vv"}, 8'(vector_valid), 8'h00);
        check({tag, "_vi"}, 8'(vector_index), 8'h00);
    endtask

    typedef struct {
        logic [7:0] ir;
        logic [7:0] imr;
        logic       inta;
        logic       ev;
        logic       es;
        logic [2:0] el;
        logic       er;
        logic       ae;
        logic [7:0] e_irr;
        logic [7:0] e_isr;
        logic       e_req;
        logic [2:0] e_idx;
        logic       e_vv;
        logic [2:0] e_vi;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [7:0] a_ir, input logic [7:0] a_imr, input logic a_inta,
                       input logic a_ev, input logic a_es, input logic [2:0] a_el,
                       input logic a_er, input logic a_ae,
                       input logic [7:0] x_irr, input logic [7:0] x_isr, input logic x_req,
                       input logic [2:0] x_idx, input logic x_vv, input logic [2:0] x_vi);
        vec_t v;
        v.ir = a_ir; v.imr = a_imr; v.inta = a_inta; v.ev = a_ev; v.es = a_es; v.el = a_el;
        v.er = a_er; v.ae = a_ae; v.e_irr = x_irr; v.e_isr = x_isr; v.e_req = x_req;
        v.e_idx = x_idx; v.e_vv = x_vv; v.e_vi = x_vi;
        tbl.push_back(v);
    endtask

    initial begin
        rst_n = 1'b0; ir = 8'h00; level_mode = 1'b0; imr = 8'h00; auto_eoi = 1'b0;
        inta_n = 1'b1; eoi_valid = 1'b0; eoi_specific = 1'b0; eoi_level = 3'd0; eoi_rotate = 1'b0;

        //      ir     imr    inta  ev    es    el    er    ae  | irr    isr    req   idx   vv    vi
        add(8'h24, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h24, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0);
        add(8'h24, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h24, 8'h00, 1'b1, 3'd2, 1'b0, 3'd0);
        add(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h24, 8'h00, 1'b1, 3'd2, 1'b0, 3'd0);
        add(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h20, 8'h04, 1'b0, 3'd2, 1'b0, 3'd0);
        add(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h20, 8'h04, 1'b0, 3'd2, 1'b0, 3'd0);
        add(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h20, 8'h04, 1'b0, 3'd2, 1'b1, 3'd2);
        add(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h20, 8'h04, 1'b0, 3'd2, 1'b0, 3'd2);
        add(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h20, 8'h04, 1'b0, 3'd5, 1'b0, 3'd2);
        add(8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 8'h20, 8'h00, 1'b0, 3'd5, 1'b0, 3'd2);
        add(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h20, 8'h00, 1'b1, 3'd5, 1'b0, 3'd2);
        add(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 8'h00, 8'h20, 1'b0, 3'd5, 1'b0, 3'd2);
        add(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 8'h00, 8'h20, 1'b0, 3'd5, 1'b0, 3'd2);
        add(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 3'd5, 1'b1, 3'd5);
        add(8'h08, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h08, 8'h00, 1'b0, 3'd5, 1'b0, 3'd5);
        add(8'h08, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h08, 8'h00, 1'b1, 3'd3, 1'b0, 3'd5);
        add(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 8'h00, 8'h08, 1'b0, 3'd3, 1'b0, 3'd5);
        add(8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 8'h00, 8'h08, 1'b0, 3'd3, 1'b0, 3'd5);
        add(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 3'd3, 1'b1, 3'd3);
        add(8'h11, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h11, 8'h00, 1'b0, 3'd3, 1'b0, 3'd3);
        add(8'h11, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h11, 8'h00, 1'b1, 3'd4, 1'b0, 3'd3);
        add(8'h11, 8'hFF, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h11, 8'h00, 1'b0, 3'd4, 1'b0, 3'd3);
        add(8'h11, 8'hFF, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h11, 8'h00, 1'b0, 3'd7, 1'b0, 3'd3);
        add(8'h11, 8'hFF, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h11, 8'h00, 1'b0, 3'd7, 1'b0, 3'd3);
        add(8'h11, 8'hFF, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 8'h11, 8'h00, 1'b0, 3'd7, 1'b1, 3'd7);
        add(8'h11, 8'hFF, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h11, 8'h00, 1'b0, 3'd7, 1'b0, 3'd7);
        add(8'h11, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h11, 8'h00, 1'b1, 3'd4, 1'b0, 3'd7);
        add(8'h11, 8'h00, 1'b1, 1'b1, 1'b1, 3'd6, 1'b1, 1'b0, 8'h11, 8'h00, 1'b1, 3'd4, 1'b0, 3'd7);
        add(8'h11, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h11, 8'h00, 1'b1, 3'd0, 1'b0, 3'd7);
        add(8'h11, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 8'h11, 8'h00, 1'b1, 3'd0, 1'b0, 3'd7);
        add(8'h11, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h11, 8'h00, 1'b1, 3'd0, 1'b0, 3'd7);

        // Reset values while rst_n is held low
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Directed vector table
        foreach (tbl[i]) begin
            ir = tbl[i].ir; imr = tbl[i].imr; inta_n = tbl[i].inta; eoi_valid = tbl[i].ev;
            eoi_specific = tbl[i].es; eoi_level = tbl[i].el; eoi_rotate = tbl[i].er;
            auto_eoi = tbl[i].ae;
            step();
            check($sformatf("tbl%0d_irr", i), irr, tbl[i].e_irr);
            check($sformatf("tbl%0d_isr", i), isr, tbl[i].e_isr);
            check($sformatf("tbl%0d_req", i), 8'(int_request), 8'(tbl[i].e_req));
            check($sformatf("tbl%0d_idx", i), 8'(interrupt_index), 8'(tbl[i].e_idx));
            check($sformatf("tbl%0d_vv", i), 8'(vector_valid), 8'(tbl[i].e_vv));
            check($sformatf("tbl%0d_vi", i), 8'(vector_index), 8'(tbl[i].e_vi));
        end
        eoi_valid = 1'b0; eoi_rotate = 1'b0; auto_eoi = 1'b0; eoi_specific = 1'b0;

        // Level mode: IRR follows ir, clears at acknowledge, re-asserts next cycle
        level_mode = 1'b1; ir = 8'h01;
        step();
        check("lvl_follow_irr", irr, 8'h01);
        check("lvl_follow_req", 8'(int_request), 8'h01);
        inta_n = 1'b0;
        step();
        check("lvl_ack_irr", irr, 8'h00);
        check("lvl_ack_isr", isr, 8'h01);
        check("lvl_ack_req", 8'(int_request), 8'h00);
        inta_n = 1'b1;
        step();
        check("lvl_reassert_irr", irr, 8'h01);

        // Reset while in ACK1 aborts the sequence
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_async");
        @(negedge clk);
        check_all_zero("rst_held");
        rst_n = 1'b1;
        step();
        check("post_rst_irr", irr, 8'h01);
        check("post_rst_vv", 8'(vector_valid), 8'h00);
        step();
        check("post_rst_req", 8'(int_request), 8'h01);
        check("post_rst_idx", 8'(interrupt_index), 8'h00);
        inta_n = 1'b0;
        step();
        check("post_rst_ack1_vv", 8'(vector_valid), 8'h00);
        check("post_rst_ack1_isr", isr, 8'h01);
        inta_n = 1'b1;
        step();
        check("post_rst_gap_vv", 8'(vector_valid), 8'h00);
        inta_n = 1'b0;
        step();
        check("post_rst_ack2_vv", 8'(vector_valid), 8'h01);
        check("post_rst_ack2_vi", 8'(vector_index), 8'h00);
        inta_n = 1'b1; eoi_valid = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd0;
        step();
        check("post_rst_eoi_isr", isr, 8'h00);
        check("post_rst_eoi_vv", 8'(vector_valid), 8'h00);
        eoi_valid = 1'b0; eoi_specific = 1'b0; ir = 8'h00; level_mode = 1'b0;

        // Randomized traffic against the reference model
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(3) == 0) ir = 8'($urandom) & 8'($urandom);
            if ($urandom_range(15) == 0) imr = 8'($urandom) & 8'($urandom) & 8'($urandom);
            if ($urandom_range(199) == 0) level_mode = ~level_mode;
            if ($urandom_range(2) == 0) inta_n = ~inta_n;
            eoi_valid    = ($urandom_range(5) == 0);
            eoi_specific = 1'($urandom_range(1));
            eoi_level    = 3'($urandom_range(7));
            eoi_rotate   = 1'($urandom_range(1));
            auto_eoi     = 1'($urandom_range(1));
            rst_n        = ($urandom_range(299) != 0);
            step();
            check("rnd_irr", irr, m_irr);
            check("rnd_isr", isr, m_isr);
            check("rnd_req", 8'(int_request), 8'(m_req));
            check("rnd_idx", 8'(interrupt_index), 8'(m_idx));
            check("rnd_vv", 8'(vector_valid), 8'(m_vv));
            check("rnd_vi", 8'(vector_index), 8'(m_vi));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/priority_resolver.md
PRIORITY_RESOLVER -- requirements
Module: priority_resolver

Interface
REQ-001 clk  input  1  single system clock; all state changes on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 ir  input  8  interrupt request lines IR7..IR0, synchronous to clk.
REQ-004 level_mode  input  1  1 = level-triggered IRR, 0 = edge-triggered IRR.
REQ-005 imr  input  8  interrupt mask; 1 masks the matching IR from arbitration.
REQ-006 auto_eoi  input  1  1 = clear the ISR bit at the second INTA.
REQ-007 inta_n  input  1  CPU interrupt acknowledge, active-low, synchronous to clk.
REQ-008 eoi_valid  input  1  one-cycle EOI command strobe.
REQ-009 eoi_specific  input  1  1 = specific EOI, 0 = non-specific EOI.
REQ-010 eoi_level  input  3  IR level for a specific EOI.
REQ-011 eoi_rotate  input  1  1 = rotate priority on this EOI or on the auto-EOI.
REQ-012 int_request  output  1  registered request to control logic.
REQ-013 interrupt_index  output  3  winning IR level; held stable while acknowledge is in progress.
REQ-014 irr  output  8  interrupt request register.
REQ-015 isr  output  8  in-service register.
REQ-016 vector_valid  output  1  one-cycle pulse at the second INTA.
REQ-017 vector_index  output  3  IR level delivered with vector_valid.

Function
REQ-018 Edge mode: irr[i] is set the cycle after ir[i] is sampled 1 following a sampled 0; it is held until acknowledge.
REQ-019 Level mode: irr[i] follows the sampled ir[i] each cycle.
REQ-020 Priority: a 3-bit lowest-priority pointer lp (reset 7) sets the order; highest priority is lp+1 mod 8, descending circularly.
REQ-021 Candidate set = irr & ~imr; the winner is the highest-priority candidate.
REQ-022 int_request is 1 only if, in IDLE, a winner exists and outranks every set isr bit (fully nested); it is registered, so IR assertion -> int_request takes 2 cycles.
REQ-023 FSM states are IDLE, ACK1 and ACK2, with edge detection on inta_n using the previous-cycle sample.
REQ-024 IDLE + inta_n falling edge -> ACK1.
    - Freeze interrupt_index to the winner, or to 7 if no winner (spurious).
    - Set isr[index] and clear irr[index], except on a spurious acknowledge, which changes neither.
    - Drop int_request to 0.
REQ-025 ACK1 + inta_n falling edge -> ACK2.
    - vector_valid = 1 and vector_index = interrupt_index for exactly that cycle.
    - If auto_eoi=1, clear isr[index], except on a spurious acknowledge.
    - If auto_eoi=1 and eoi_rotate=1, set lp = index.
REQ-026 ACK2 -> IDLE on the next cycle unconditionally; int_request is re-evaluated from IDLE.
REQ-027 Non-specific EOI clears the highest-priority set isr bit; with isr=0 it is a no-op and lp is unchanged.
REQ-028 Specific EOI clears isr[eoi_level], even if that bit is already 0.
REQ-029 EOI with eoi_rotate=1 sets lp to the cleared level; a no-op EOI does not rotate.
REQ-030 EOI is accepted in any state.
    - The non-specific target is computed from isr before any same-cycle set.
    - A same-cycle ISR set is applied first, then the EOI clear.
REQ-031 In level mode, an irr bit cleared at acknowledge re-asserts next cycle if ir is still high.
REQ-032 Mask changes take effect on the next arbitration cycle; they never alter a frozen interrupt_index.

Reset
REQ-033 While rst_n=0, all of the following are held:
    - irr = 0, isr = 0, lp = 7
    - int_request = 0, interrupt_index = 0
    - vector_valid = 0, vector_index = 0
    - state = IDLE
    - the stored ir/inta_n samples: ir = 0, inta_n = 1
REQ-034 Reset asserted mid-acknowledge aborts the sequence; no vector_valid is produced afterwards.

Verification
REQ-035 Setup: edge mode, imr=0, ir=0x24.
    - irr=0x24 one cycle later; int_request=1 one cycle after that.
    - interrupt_index=2.
REQ-036 Full INTA pair on the REQ-035 state.
    - After the first INTA: isr=0x04, irr=0x20, int_request=0.
    - At the second INTA: vector_valid=1, vector_index=2.
REQ-037 Setup: isr=0x04, then ir5 asserted.
    - int_request stays 0, because IR5 does not outrank IR2.
    - Non-specific EOI -> isr=0 -> int_request=1, interrupt_index=5.
REQ-038 Setup: auto_eoi=1, eoi_rotate=1, IR3 acknowledged.
    - isr returns to 0 at the second INTA; lp=3.
    - Next with ir=0x11 pending: interrupt_index=4.
REQ-039 Setup: imr=0xFF and an INTA pair.
    - interrupt_index=7, vector_index=7.
    - isr and irr are unchanged.
REQ-040 Setup: rst_n pulsed low in ACK1.
    - All outputs are 0 and state is IDLE.
    - A following inta_n edge is treated as a first acknowledge.
